pc_redirect_ctrl: RTL
=====================

# pc_redirect_ctrl

Sequences program-counter redirection in the 5-stage pipeline. Consumes the decode-stage jump selection (0 none, 1 J/JAL, 2 JR) and the execute-stage branch resolution. Arbitrates between them and drives PC source select, redirect target, IF/ID stall and pipeline flush controls. Also holds a JR in decode until its rs operand is available through forwarding, and keeps a saturating redirect counter for performance monitoring.

## Interface
Parameters:
- FLUSH_CYCLES, 1, cycles of IF/ID + ID/EX flush after a taken EX branch (1..7; 1 = redirect cycle only)
- JR_MAX_WAIT, 3, JR_WAIT cycles after which jr_timeout is set (1..15)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- id_valid  in  1  decode stage holds a valid instruction
- jsel_id  in  2  jump class of decode instruction: 0 none, 1 J/JAL, 2 JR, 3 treated as 0
- j_target  in  32  J/JAL target computed in decode
- jr_target  in  32  rs value after forwarding mux
- jr_rs_ready  in  1  rs value in jr_target is valid this cycle
- br_taken_ex  in  1  branch in EX resolved taken
- br_target_ex  in  32  branch target from EX
- pc_sel  out  2  PC source: 0 PC+4, 1 jump, 2 JR, 3 branch
- redirect_pc  out  32  target matching pc_sel; 0 when pc_sel=0
- stall_if_id  out  1  hold PC and IF/ID register
- flush_if_id  out  1  zero IF/ID register
- flush_id_ex  out  1  insert bubble into ID/EX
- jr_timeout  out  1  sticky: JR wait exceeded JR_MAX_WAIT
- redirect_cnt  out  16  count of redirect cycles, saturating at 0xFFFF

## Operation
- States: IDLE, JR_WAIT, FLUSH. Registered: state, flush counter (3b), wait counter (4b), jr_timeout, redirect_cnt. All other outputs are combinational from state and inputs.
- Priority in every state: br_taken_ex > JR > J/JAL. The EX instruction is older, so a taken branch cancels any decode jump.
- IDLE:
  - br_taken_ex: pc_sel=3, redirect_pc=br_target_ex, flush_if_id=1, flush_id_ex=1. Go to FLUSH with counter FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in IDLE.
  - Else if id_valid and jsel_id=1: pc_sel=1, redirect_pc=j_target, flush_if_id=1. Stay in IDLE.
  - Else if id_valid, jsel_id=2 and jr_rs_ready: pc_sel=2, redirect_pc=jr_target, flush_if_id=1.
  - Else if id_valid, jsel_id=2 and not jr_rs_ready: stall_if_id=1, flush_id_ex=1. Go to JR_WAIT with wait counter 1.
  - Otherwise all outputs are 0.
- JR_WAIT:
  - br_taken_ex: identical to the IDLE branch case, and the JR is abandoned.
  - Else if jr_rs_ready: pc_sel=2, redirect_pc=jr_target, flush_if_id=1. Go to IDLE.
  - Else: stall_if_id=1, flush_id_ex=1, and the wait counter increments (saturating at 15). When the counter reaches JR_MAX_WAIT, set jr_timeout; keep waiting.
- FLUSH:
  - flush_if_id=1, flush_id_ex=1, pc_sel=0, stall_if_id=0.
  - jsel_id and br_taken_ex are ignored (wrong path or bubble).
  - Counter decrements each cycle; go to IDLE in the cycle the counter is 1.
- redirect_cnt increments (saturating) on every cycle with pc_sel≠0.
- jr_timeout is cleared only by RST.

## Timing
- Reset (RST high at a rising edge) forces state=IDLE, both counters=0, jr_timeout=0, redirect_cnt=0. This takes effect regardless of state, including mid-JR_WAIT or mid-FLUSH.
- With idle inputs after reset: pc_sel=0, redirect_pc=0, stall_if_id=0, flush_if_id=0, flush_id_ex=0.
- Redirect latency: 0 cycles combinational. PC loads redirect_pc at the same rising edge at which pc_sel≠0 is sampled.
- J/JAL costs 1 bubble. JR costs 1 bubble plus the number of JR_WAIT cycles. A taken branch costs 2 bubbles plus FLUSH_CYCLES-1.
- stall_if_id and flush_if_id are never both 1.
- pc_sel≠0 never occurs in FLUSH.

## Test plan
- Reset: RST=1 for 2 cycles with all inputs active. Required: all outputs 0 and state IDLE. Then id_valid=1, jsel_id=1, j_target=0x00400040 → pc_sel=1, redirect_pc=0x00400040, flush_if_id=1, redirect_cnt=1 next cycle.
- Simultaneous jump and branch: jsel_id=1, j_target=0x100, br_taken_ex=1, br_target_ex=0x200, FLUSH_CYCLES=1 → pc_sel=3, redirect_pc=0x200, both flushes=1. Next cycle all 0 if inputs drop.
- JR hazard: jsel_id=2 with jr_rs_ready low for 2 cycles, then high with jr_target=0x3C → 2 cycles of stall_if_id=1 and flush_id_ex=1, then pc_sel=2, redirect_pc=0x3C, flush_if_id=1, state IDLE. jr_timeout stays 0.
- Branch during JR_WAIT: enter JR_WAIT, then br_taken_ex=1 with br_target_ex=0x80 → pc_sel=3 and redirect_pc=0x80. JR is abandoned; the next cycle with jsel_id=0 shows no stall.
- FLUSH_CYCLES=3: taken branch → redirect cycle plus 2 FLUSH cycles with both flushes=1 and pc_sel=0. jsel_id=1 asserted during FLUSH is ignored.
- Timeout and saturation:
  - JR_MAX_WAIT=3 with jr_rs_ready held low 5 cycles → jr_timeout=1 from the cycle after the 3rd wait cycle onward, and it remains set after the JR completes.
  - Force 65540 J redirects → redirect_cnt holds 0xFFFF.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates EX branches against decode J/JAL and JR,
// holds a JR until its rs operand arrives, and counts redirect cycles.
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int JR_MAX_WAIT  = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        id_valid,
  input  logic [1:0]  jsel_id,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  input  logic        jr_rs_ready,
  input  logic        br_taken_ex,
  input  logic [31:0] br_target_ex,
  output logic [1:0]  pc_sel,
  output logic [31:0] redirect_pc,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        jr_timeout,
  output logic [15:0] redirect_cnt
);

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);
  localparam logic [3:0] MaxWait   = 4'(JR_MAX_WAIT);
  localparam bit         UseFlush  = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        jr_timeout_q, jr_timeout_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  logic       isJ;
  logic       isJr;
  logic [3:0] waitInc;

  assign isJ     = id_valid && (jsel_id == 2'd1);
  assign isJr    = id_valid && (jsel_id == 2'd2);
  assign waitInc = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;

  // A taken EX branch is older than anything in decode, so it wins in every
  // state except FLUSH, where EX holds a bubble or wrong-path instruction.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    jr_timeout_d = jr_timeout_q;
    pc_sel       = 2'd0;
    redirect_pc  = 32'd0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;

    if (!RST) begin
      if (state_q == FLUSH) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) begin
          state_d     = IDLE;
          flush_cnt_d = 3'd0;
        end
      end else if (br_taken_ex) begin
        pc_sel      = 2'd3;
        redirect_pc = br_target_ex;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        wait_cnt_d  = 4'd0;
        if (UseFlush) begin
          state_d     = FLUSH;
          flush_cnt_d = FlushInit;
        end else begin
          state_d = IDLE;
        end
      end else if (state_q == JR_WAIT) begin
        if (jr_rs_ready) begin
          pc_sel      = 2'd2;
          redirect_pc = jr_target;
          flush_if_id = 1'b1;
          state_d     = IDLE;
          wait_cnt_d  = 4'd0;
        end else begin
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          wait_cnt_d  = waitInc;
          if (waitInc >= MaxWait) jr_timeout_d = 1'b1;
        end
      end else if (isJ) begin
        pc_sel      = 2'd1;
        redirect_pc = j_target;
        flush_if_id = 1'b1;
      end else if (isJr) begin
        if (jr_rs_ready) begin
          pc_sel      = 2'd2;
          redirect_pc = jr_target;
          flush_if_id = 1'b1;
        end else begin
          // The decode cycle that discovers the hazard is the first wait cycle.
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = JR_WAIT;
          wait_cnt_d  = 4'd1;
          if (MaxWait <= 4'd1) jr_timeout_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    if ((pc_sel != 2'd0) && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_d = redirect_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      flush_cnt_q    <= 3'd0;
      wait_cnt_q     <= 4'd0;
      jr_timeout_q   <= 1'b0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      jr_timeout_q   <= jr_timeout_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign jr_timeout   = jr_timeout_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule
